// File: rtl/j202_soc_boot_ctrl.sv
// Wishbone boot/reset controller for j202_soc_core: register file, debounced START_n,
// reset-stretch sequencer and boot-mode latch. Optional run-entry IRQ: J202_SOC_BOOT_CTRL_IRQ_EN.
module j202_soc_boot_ctrl #(
   parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
   parameter int unsigned DEB_CYCLES = 16,
   parameter logic [15:0] RSTLEN_DEF = 16'd64
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   input  logic        start_n_i,
   input  logic [1:0]  md_boot_i,
   output logic        core_rst_n_o,
   output logic [1:0]  md_boot_o,
   output logic        irq_o
);

   localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);

   typedef enum logic [1:0] {
      HALT    = 2'd0,
      STRETCH = 2'd1,
      RUN     = 2'd2
   } state_t;

   state_t      state, state_d;
   logic [15:0] stretch_cnt, stretch_cnt_d;
   logic [1:0]  md_boot_d;
   logic        run_set;

   logic [3:0]  ctrl, ctrl_d;
   logic [15:0] rstlen, rstlen_d;
   logic [31:0] scratch, scratch_d;
   logic        seen, seen_d;
   logic        run_irq_rd;

   logic [1:0]       start_sync;
   logic [DEB_W-1:0] deb_cnt;
   logic             start_evt;

   logic        valid, acc, wr;
   logic [31:0] rdata;

   logic unused_adr;
   assign unused_adr = ^wbs_adr_i[1:0];

   assign valid = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
   assign acc   = valid & ~wbs_ack_o;
   assign wr    = acc & wbs_we_i;

   // Event fires in the cycle the low-sample counter steps onto DEB_CYCLES
   assign start_evt = ~start_sync[1] & (deb_cnt == DEB_W'(DEB_CYCLES - 1));

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         start_sync <= 2'b11;
         deb_cnt    <= '0;
      end else begin
         start_sync <= {start_sync[0], start_n_i};
         if (start_sync[1])
            deb_cnt <= '0;
         else if (deb_cnt != DEB_W'(DEB_CYCLES))
            deb_cnt <= deb_cnt + DEB_W'(1);
      end
   end

   // Register writes; the start event is applied after any same-cycle CTRL write
   always_comb begin
      ctrl_d    = ctrl;
      rstlen_d  = rstlen;
      scratch_d = scratch;
      seen_d    = seen;
      if (wr) begin
         case (wbs_adr_i[3:2])
            2'd0: if (wbs_sel_i[0]) ctrl_d = wbs_dat_i[3:0];
            2'd1: if (wbs_sel_i[0] && wbs_dat_i[3]) seen_d = 1'b0;
            2'd2: begin
               if (wbs_sel_i[0]) rstlen_d[7:0]  = wbs_dat_i[7:0];
               if (wbs_sel_i[1]) rstlen_d[15:8] = wbs_dat_i[15:8];
            end
            default: begin
               for (int b = 0; b < 4; b++)
                  if (wbs_sel_i[b]) scratch_d[b*8 +: 8] = wbs_dat_i[b*8 +: 8];
            end
         endcase
      end
      if (start_evt) begin
         ctrl_d[0] = 1'b1;
         seen_d    = 1'b1;
      end
   end

   always_comb begin
      rdata = 32'd0;
      case (wbs_adr_i[3:2])
         2'd0:    rdata = {28'd0, ctrl};
         2'd1:    rdata = {25'd0, run_irq_rd, md_boot_o, seen, 2'(state), core_rst_n_o};
         2'd2:    rdata = {16'd0, rstlen};
         default: rdata = scratch;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= 32'd0;
         ctrl      <= 4'd0;
         rstlen    <= RSTLEN_DEF;
         scratch   <= 32'd0;
         seen      <= 1'b0;
      end else begin
         wbs_ack_o <= acc;
         if (acc)
            wbs_dat_o <= wbs_we_i ? 32'd0 : rdata;
         ctrl    <= ctrl_d;
         rstlen  <= rstlen_d;
         scratch <= scratch_d;
         seen    <= seen_d;
      end
   end

   // Sequencer: HALT -> STRETCH (RSTLEN+1 cycles) -> RUN; clearing RUN always returns to HALT
   always_comb begin
      state_d       = state;
      stretch_cnt_d = stretch_cnt;
      md_boot_d     = md_boot_o;
      run_set       = 1'b0;
      case (state)
         HALT: begin
            if (ctrl[0]) begin
               state_d       = STRETCH;
               stretch_cnt_d = rstlen;
               md_boot_d     = ctrl[1] ? ctrl[3:2] : md_boot_i;
            end
         end
         STRETCH: begin
            if (!ctrl[0]) begin
               state_d = HALT;
            end else if (stretch_cnt == 16'd0) begin
               state_d = RUN;
               run_set = 1'b1;
            end else begin
               stretch_cnt_d = stretch_cnt - 16'd1;
            end
         end
         RUN: begin
            if (!ctrl[0]) state_d = HALT;
         end
         default: state_d = HALT;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state        <= HALT;
         stretch_cnt  <= 16'd0;
         md_boot_o    <= 2'b00;
         core_rst_n_o <= 1'b0;
      end else begin
         state        <= state_d;
         stretch_cnt  <= stretch_cnt_d;
         md_boot_o    <= md_boot_d;
         core_rst_n_o <= (state_d == RUN);
      end
   end

`ifdef J202_SOC_BOOT_CTRL_IRQ_EN
   logic irq_clr;
   assign irq_clr = wr & (wbs_adr_i[3:2] == 2'd1) & wbs_sel_i[0] & wbs_dat_i[6];

   // Set has priority over a same-cycle W1C
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i)
         irq_o <= 1'b0;
      else if (run_set)
         irq_o <= 1'b1;
      else if (irq_clr)
         irq_o <= 1'b0;
   end
   assign run_irq_rd = irq_o;
`else
   logic unused_run_set;
   assign unused_run_set = run_set;
   assign irq_o      = 1'b0;
   assign run_irq_rd = 1'b0;
`endif

endmodule

// File: tb/tb_j202_soc_boot_ctrl.sv
// Directed self-checking bench for j202_soc_boot_ctrl (default parameters).
// Expectations follow J202_SOC_BOOT_CTRL_IRQ_EN when the bench is built with it.
module tb_j202_soc_boot_ctrl;

   localparam logic [31:0] BASE = 32'h3000_0000;
`ifdef J202_SOC_BOOT_CTRL_IRQ_EN
   localparam logic [31:0] IRQ_BIT = 32'h40;
   localparam logic        IRQ_EXP = 1'b1;
`else
   localparam logic [31:0] IRQ_BIT = 32'h00;
   localparam logic        IRQ_EXP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        stb, cyc, we;
   logic [3:0]  sel;
   logic [31:0] adr, dat_w;
   logic        ack;
   logic [31:0] dat_r;
   logic        start_n;
   logic [1:0]  md_in;
   logic        core_rst_n;
   logic [1:0]  md_out;
   logic        irq;

   int checks = 0;
   int errors = 0;
   logic [31:0] rd;

   always #5 clk = ~clk;

   j202_soc_boot_ctrl dut (
      .wb_clk_i     (clk),
      .wb_rst_i     (rst),
      .wbs_stb_i    (stb),
      .wbs_cyc_i    (cyc),
      .wbs_we_i     (we),
      .wbs_sel_i    (sel),
      .wbs_adr_i    (adr),
      .wbs_dat_i    (dat_w),
      .wbs_ack_o    (ack),
      .wbs_dat_o    (dat_r),
      .start_n_i    (start_n),
      .md_boot_i    (md_in),
      .core_rst_n_o (core_rst_n),
      .md_boot_o    (md_out),
      .irq_o        (irq)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Returns #1 after the acknowledging edge
   task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] q);
      bit got = 0;
      q   = 32'hx;
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
      for (int i = 0; i < 8 && !got; i++) begin
         @(posedge clk);
         #1;
         if (ack) begin
            got = 1;
            q   = dat_r;
         end
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      if (!got) begin
         checks++;
         errors++;
         $error("FAIL wb_timeout: no ack at addr %h", a);
      end
   endtask

   task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] q;
      wb_xfer(1'b1, a, d, s, q);
   endtask

   task automatic wb_read(input logic [31:0] a, output logic [31:0] q);
      wb_xfer(1'b0, a, 32'd0, 4'hF, q);
   endtask

   initial begin
      int acks;
      rst = 1'b1; stb = 0; cyc = 0; we = 0; sel = 0; adr = 0; dat_w = 0;
      start_n = 1'b1; md_in = 2'b00;
      tick(3);
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_dat", dat_r, 32'd0);
      check("rst_core_rst_n", 32'(core_rst_n), 32'd0);
      check("rst_md_boot", 32'(md_out), 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      rst = 1'b0;
      tick(1);

      wb_read(BASE + 32'h0, rd); check("rd_ctrl_rst", rd, 32'h0);
      wb_read(BASE + 32'h4, rd); check("rd_status_rst", rd, 32'h0);
      wb_read(BASE + 32'h8, rd); check("rd_rstlen_rst", rd, 32'h40);

      // Stretch of RSTLEN=5: six reset cycles after leaving HALT
      wb_write(BASE + 32'h8, 32'd5, 4'hF);
      wb_write(BASE + 32'h0, 32'h1, 4'hF);
      for (int i = 0; i < 6; i++) begin
         tick(1);
         check($sformatf("stretch5_low_%0d", i), 32'(core_rst_n), 32'd0);
      end
      tick(1);
      check("stretch5_high", 32'(core_rst_n), 32'd1);
      check("irq_after_run", 32'(irq), 32'(IRQ_EXP));
      wb_read(BASE + 32'h4, rd); check("status_run", rd, 32'h05 | IRQ_BIT);
      wb_write(BASE + 32'h4, 32'h40, 4'h1);
      check("irq_cleared", 32'(irq), 32'd0);
      wb_read(BASE + 32'h4, rd); check("status_irq_clr", rd, 32'h05);

      // Clear RUN while running
      wb_write(BASE + 32'h0, 32'h0, 4'hF);
      check("run_clr_same", 32'(core_rst_n), 32'd1);
      tick(1);
      check("run_clr_next", 32'(core_rst_n), 32'd0);

      // Clear RUN during STRETCH
      wb_write(BASE + 32'h8, 32'd20, 4'hF);
      wb_write(BASE + 32'h0, 32'h1, 4'hF);
      tick(2);
      wb_read(BASE + 32'h4, rd); check("status_stretch", rd, 32'h02);
      wb_write(BASE + 32'h0, 32'h0, 4'hF);
      tick(1);
      wb_read(BASE + 32'h4, rd); check("status_halt_from_stretch", rd, 32'h00);
      check("core_rst_after_stretch_clr", 32'(core_rst_n), 32'd0);

      // Boot-mode override and stability during RUN
      md_in = 2'b01;
      wb_write(BASE + 32'h0, 32'hB, 4'hF);
      tick(2);
      check("md_ovr_latched", 32'(md_out), 32'd2);
      md_in = 2'b11;
      tick(30);
      check("md_ovr_core_run", 32'(core_rst_n), 32'd1);
      check("md_stable_in_run", 32'(md_out), 32'd2);
      wb_read(BASE + 32'h0, rd); check("rd_ctrl_ovr", rd, 32'hB);
      wb_write(BASE + 32'h0, 32'h0, 4'hF);
      tick(2);

      // Pin-sourced boot mode with RSTLEN=0: one STRETCH cycle
      wb_write(BASE + 32'h8, 32'd0, 4'hF);
      wb_write(BASE + 32'h0, 32'h1, 4'hF);
      tick(1);
      check("rstlen0_stretch", 32'(core_rst_n), 32'd0);
      check("md_pins_latched", 32'(md_out), 32'd3);
      tick(1);
      check("rstlen0_run", 32'(core_rst_n), 32'd1);
      wb_write(BASE + 32'h0, 32'h0, 4'hF);
      tick(2);
      wb_write(BASE + 32'h4, 32'h48, 4'h1);

      // START_n: short pulse ignored, long low gives one event
      start_n = 1'b0;
      tick(10);
      start_n = 1'b1;
      tick(10);
      wb_read(BASE + 32'h4, rd); check("short_pulse_status", rd, 32'h30);
      wb_read(BASE + 32'h0, rd); check("short_pulse_ctrl", rd, 32'h0);
      start_n = 1'b0;
      tick(25);
      check("start_core_run", 32'(core_rst_n), 32'd1);
      wb_read(BASE + 32'h4, rd); check("start_status", rd, 32'h3D | IRQ_BIT);
      wb_write(BASE + 32'h0, 32'h0, 4'hF);
      tick(10);
      check("held_low_single_event", 32'(core_rst_n), 32'd0);
      wb_read(BASE + 32'h0, rd); check("held_low_ctrl", rd, 32'h0);
      wb_write(BASE + 32'h4, 32'h48, 4'h1);
      wb_read(BASE + 32'h4, rd); check("seen_w1c", rd, 32'h30);
      start_n = 1'b1;

      // Byte selects on SCRATCH
      wb_write(BASE + 32'hC, 32'hDEAD_BEEF, 4'hF);
      wb_write(BASE + 32'hC, 32'h1122_3344, 4'b0101);
      wb_read(BASE + 32'hC, rd); check("scratch_bytes", rd, 32'hDE22_BE44);

      // Out-of-range address must not ack
      acks = 0;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h10; sel = 4'hF;
      for (int i = 0; i < 6; i++) begin
         tick(1);
         if (ack) acks++;
      end
      cyc = 1'b0; stb = 1'b0;
      check("no_ack_oor", 32'(acks), 32'd0);

      // Reset in the middle of RUN
      wb_write(BASE + 32'h0, 32'h1, 4'hF);
      tick(3);
      check("pre_reset_run", 32'(core_rst_n), 32'd1);
      rst = 1'b1;
      tick(1);
      check("midrst_core", 32'(core_rst_n), 32'd0);
      check("midrst_md", 32'(md_out), 32'd0);
      rst = 1'b0;
      tick(1);
      wb_read(BASE + 32'h8, rd); check("midrst_rstlen", rd, 32'h40);
      wb_read(BASE + 32'hC, rd); check("midrst_scratch", rd, 32'h0);
      wb_read(BASE + 32'h0, rd); check("midrst_ctrl", rd, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
